// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter (fetch = master 0, memu = master 1) with one owner per transaction.
// Optional watchdog abort compiled in with `define ARB_TIMEOUT_EN.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter bit          RR_EN          = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  dbus_req_t  m0_req,
    output dbus_resp_t m0_resp,
    input  dbus_req_t  m1_req,
    output dbus_resp_t m1_resp,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       owner,
    output logic       busy,
    output logic       timeout_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("dbus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state_reg, state_next;
    logic       owner_reg, owner_next;
    logic       last_grant_reg, last_grant_next;
    logic       winner;
    logic       any_valid;
    logic       timeout_hit;
    dbus_resp_t owner_resp;
    dbus_req_t  req_arr [2];
    dbus_resp_t resp_arr[2];

    assign req_arr[0] = m0_req;
    assign req_arr[1] = m1_req;
    assign any_valid  = m0_req.valid | m1_req.valid;

    // On contention, round-robin favours the master that did not win last time.
    always_comb begin
        winner = m1_req.valid;
        if (m0_req.valid && m1_req.valid) begin
            winner = RR_EN ? ~last_grant_reg : 1'b1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    owner_next      = winner;
                    last_grant_next = winner;
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                if (dresp.data_ok || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_reg, wd_next;

    // Counter holds the number of BUSY cycles already elapsed, so the limit fires
    // in the TIMEOUT_CYCLES-th BUSY cycle; a coincident data_ok wins.
    always_comb begin
        wd_next = '0;
        if (state_reg == BUSY && !dresp.data_ok) begin
            wd_next = wd_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end

    assign timeout_hit = (state_reg == BUSY) && !dresp.data_ok &&
                         (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // A watchdog abort completes the owner's transfer with zero data so it unblocks.
    always_comb begin
        owner_resp = dresp;
        if (timeout_hit) begin
            owner_resp.data_ok = 1'b1;
            owner_resp.data    = '0;
        end
    end

    assign dreq = (state_reg == BUSY) ? req_arr[owner_reg] : '0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign resp_arr[gi] = (state_reg == BUSY && owner_reg == 1'(gi)) ? owner_resp : '0;
    end

    assign m0_resp     = resp_arr[0];
    assign m1_resp     = resp_arr[1];
    assign owner       = owner_reg;
    assign busy        = (state_reg == BUSY);
    assign timeout_err = timeout_hit;
endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench: fixed-priority and round-robin instances driven by the same masters and slave.
// Build with ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_dbus_arbiter;
    import dbus_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    dbus_req_t  m0_req, m1_req;
    dbus_resp_t dresp;

    dbus_resp_t fp_m0_resp, fp_m1_resp, rr_m0_resp, rr_m1_resp;
    dbus_req_t  fp_dreq, rr_dreq;
    logic       fp_owner, fp_busy, fp_terr;
    logic       rr_owner, rr_busy, rr_terr;

    always #5 clk = ~clk;

    dbus_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_resp(fp_m0_resp),
        .m1_req(m1_req), .m1_resp(fp_m1_resp),
        .dreq(fp_dreq), .dresp(dresp),
        .owner(fp_owner), .busy(fp_busy), .timeout_err(fp_terr)
    );

    dbus_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_resp(rr_m0_resp),
        .m1_req(m1_req), .m1_resp(rr_m1_resp),
        .dreq(rr_dreq), .dresp(dresp),
        .owner(rr_owner), .busy(rr_busy), .timeout_err(rr_terr)
    );

    typedef struct {
        logic        who;
        logic [63:0] val;
    } exp_t;

    exp_t gq[2][$];
    exp_t rq[2][$];
    logic cur_owner[2];
    logic prev_busy[2];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   in_to   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_g(input int id, input logic who, input logic [63:0] addr);
        exp_t e;
        e.who = who;
        e.val = addr;
        gq[id].push_back(e);
    endtask

    task automatic push_r(input int id, input logic who, input logic [63:0] data);
        exp_t e;
        e.who = who;
        e.val = data;
        rq[id].push_back(e);
    endtask

    task automatic mon(input int id, input dbus_req_t dq, input dbus_resp_t r0,
                       input dbus_resp_t r1, input logic bz, input logic ow, input logic te);
        exp_t      e;
        dbus_req_t sel;
        if (bz && !prev_busy[id]) begin
            if (gq[id].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL grant_unexpected[%0d]: owner %0d addr %h, expected no grant", id, ow, dq.addr);
                cur_owner[id] = ow;
            end else begin
                e = gq[id].pop_front();
                check($sformatf("grant_owner[%0d]", id), ow, e.who);
                check($sformatf("grant_addr[%0d]", id), dq.addr, e.val);
                cur_owner[id] = e.who;
            end
        end
        if (bz) begin
            sel = cur_owner[id] ? m1_req : m0_req;
            check($sformatf("fwd_valid[%0d]", id), dq.valid, sel.valid);
            check($sformatf("fwd_addr[%0d]", id), dq.addr, sel.addr);
        end else begin
            check($sformatf("idle_quiet[%0d]", id), {dq.valid, r0.data_ok, r1.data_ok}, 0);
        end
        if (r0.data_ok || r1.data_ok) begin
            if (rq[id].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_unexpected[%0d]: m0 data_ok %0d m1 data_ok %0d, expected none", id, r0.data_ok, r1.data_ok);
            end else begin
                e = rq[id].pop_front();
                check($sformatf("resp_who[%0d]", id), r1.data_ok, e.who);
                check($sformatf("resp_data[%0d]", id), e.who ? r1.data : r0.data, e.val);
                check($sformatf("resp_other_zero[%0d]", id), e.who ? r0 : r1, 0);
            end
        end
        if (!in_to) check($sformatf("terr_low[%0d]", id), te, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, fp_dreq, fp_m0_resp, fp_m1_resp, fp_busy, fp_owner, fp_terr);
            mon(1, rr_dreq, rr_m0_resp, rr_m1_resp, rr_busy, rr_owner, rr_terr);
        end
        prev_busy[0] = fp_busy;
        prev_busy[1] = rr_busy;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic dbus_req_t mkreq(input logic [63:0] a);
        dbus_req_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.addr   = a;
        r.size   = 3'd3;
        return r;
    endfunction

    task automatic do_reset;
        m0_req = '0;
        m1_req = '0;
        dresp  = '0;
        rst    = 1'b1;
        step;
        rst    = 1'b0;
    endtask

    // Called in BUSY cycle 1; data_ok lands in BUSY cycle delay+1, returns in the following IDLE cycle.
    task automatic respond(input int delay, input logic [63:0] d);
        repeat (delay) step;
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = d;
        step;
        dresp = '0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy_fp"}, fp_busy, 0);
        check({name, "_busy_rr"}, rr_busy, 0);
    endtask

    localparam logic [63:0] D_RR [4] = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                                         64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};

    initial begin
        prev_busy[0] = 1'b0;
        prev_busy[1] = 1'b0;
        cur_owner[0] = 1'b0;
        cur_owner[1] = 1'b0;
        m0_req = '0;
        m1_req = '0;
        dresp  = '0;
        rst    = 1'b1;
        step;
        step;
        check("rst_busy", {fp_busy, rr_busy}, 0);
        check("rst_owner", {fp_owner, rr_owner}, 0);
        check("rst_dreq_valid", {fp_dreq.valid, rr_dreq.valid}, 0);
        check("rst_terr", {fp_terr, rr_terr}, 0);
        rst = 1'b0;
        step;

        // Single m1 read; data_ok three cycles after grant.
        m1_req = mkreq(64'h8000_0010);
        for (int id = 0; id < 2; id++) begin
            push_g(id, 1'b1, 64'h8000_0010);
            push_r(id, 1'b1, 64'hDEAD_BEEF_0123_4567);
        end
        check("lat_no_dreq_yet", fp_dreq.valid, 0);
        step;
        check("lat_dreq_next", fp_dreq.valid, 1);
        respond(3, 64'hDEAD_BEEF_0123_4567);
        m1_req = '0;
        check_idle("t1_done");
        step;

        // Contention after reset: m1 first in both policies; m0 stalls with its address hidden.
        do_reset;
        m0_req = mkreq(64'h8000_0000);
        m1_req = mkreq(64'h8000_0020);
        for (int id = 0; id < 2; id++) begin
            push_g(id, 1'b1, 64'h8000_0020);
            push_g(id, 1'b0, 64'h8000_0000);
            push_r(id, 1'b1, 64'hAAAA_5555_0000_0020);
            push_r(id, 1'b0, 64'h5555_AAAA_0000_0000);
        end
        step;
        check("contend_owner_fp", fp_owner, 1);
        respond(2, 64'hAAAA_5555_0000_0020);
        m1_req = '0;
        check_idle("t2_gap");
        step;
        check("m0_after_gap", fp_owner, 0);
        respond(1, 64'h5555_AAAA_0000_0000);
        m0_req = '0;
        check_idle("t2_done");
        step;

        // Both masters continuously valid for four transactions.
        do_reset;
        m0_req = mkreq(64'h8000_0100);
        m1_req = mkreq(64'h8000_0200);
        for (int i = 0; i < 4; i++) begin
            push_g(0, 1'b1, 64'h8000_0200);
            push_r(0, 1'b1, D_RR[i]);
            push_g(1, (i % 2 == 0), (i % 2 == 0) ? 64'h8000_0200 : 64'h8000_0100);
            push_r(1, (i % 2 == 0), D_RR[i]);
        end
        for (int i = 0; i < 4; i++) begin
            step;
            check("rr_order", rr_owner, (i % 2 == 0));
            respond(1, D_RR[i]);
            check_idle("t3_gap");
        end
        m0_req = '0;
        m1_req = '0;
        step;

        // Reset in the 2nd BUSY cycle; a late data_ok must be ignored.
        do_reset;
        m1_req = mkreq(64'h8000_0300);
        push_g(0, 1'b1, 64'h8000_0300);
        push_g(1, 1'b1, 64'h8000_0300);
        step;
        step;
        rst = 1'b1;
        step;
        check("mid_rst_dreq_valid", {fp_dreq.valid, rr_dreq.valid}, 0);
        check("mid_rst_busy", {fp_busy, rr_busy}, 0);
        check("mid_rst_owner", {fp_owner, rr_owner}, 0);
        rst    = 1'b0;
        m1_req = '0;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hBAD0_BAD0_BAD0_BAD0;
        step;
        dresp = '0;
        check_idle("late_dok");
        step;

`ifdef ARB_TIMEOUT_EN
        // Silent slave: watchdog aborts in the 8th BUSY cycle.
        do_reset;
        in_to  = 1'b1;
        m0_req = mkreq(64'h8000_0400);
        for (int id = 0; id < 2; id++) begin
            push_g(id, 1'b0, 64'h8000_0400);
            push_r(id, 1'b0, 64'h0);
        end
        step;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("to_err_fp_c%0d", k), fp_terr, (k == 8));
            check($sformatf("to_err_rr_c%0d", k), rr_terr, (k == 8));
            if (k < 8) step;
        end
        check("to_dok", fp_m0_resp.data_ok, 1);
        m0_req = '0;
        step;
        in_to = 1'b0;
        check_idle("to_done");
        step;
`endif

        step;
        check("grant_q_left_fp", gq[0].size(), 0);
        check("grant_q_left_rr", gq[1].size(), 0);
        check("resp_q_left_fp", rq[0].size(), 0);
        check("resp_q_left_rr", rq[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master arbiter sharing the single data-bus port between instruction fetch (master 0) and the memory unit (master 1).
- Sits between the core's request generators and the top-level dbus.
- Latches one owner per transaction and forwards only that owner's request.
- Routes the bus response back to the owner and blocks the other master until the owner's data_ok.

Parameters:
- RR_EN, 0, arbitration policy: 0 = fixed priority (master 1 wins), 1 = round-robin (master not granted last wins).
- TIMEOUT_CYCLES, 255, watchdog limit in cycles while BUSY; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  dbus_req_t  master 0 (fetch) request.
- m0_resp  out  dbus_resp_t  response to master 0.
- m1_req  in  dbus_req_t  master 1 (memu) request.
- m1_resp  out  dbus_resp_t  response to master 1.
- dreq  out  dbus_req_t  request to shared dbus.
- dresp  in  dbus_resp_t  response from shared dbus.
- owner  out  1  current/last granted master index.
- busy  out  1  high while a transaction is in flight.
- timeout_err  out  1  one-cycle pulse on watchdog abort; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On rst: state=IDLE, owner=0, last_grant=0 (so the first round-robin contention goes to master 1), busy=0, timeout_err=0, watchdog=0.
  - Reset mid-transaction abandons the transaction at once; dreq.valid is 0 from the following cycle.
- States: IDLE, BUSY.
- IDLE:
  - dreq is all-zero; m0_resp and m1_resp are all-zero.
  - If any mX_req.valid=1, arbitrate and register the winner into owner. Next state BUSY, busy=1.
  - Arbitration latency is one cycle: a request valid in cycle N appears on dreq in cycle N+1.
- Arbitration:
  - Only one master valid: that master wins.
  - Both valid, RR_EN=0: master 1 wins.
  - Both valid, RR_EN=1: the master != last_grant wins.
  - last_grant is updated with owner on every grant.
- BUSY:
  - dreq = owner's request, forwarded combinationally every cycle, so owner-side changes pass through.
  - Owner's resp = dresp (addr_ok, data_ok, data passed through); non-owner resp is all-zero.
- Completion:
  - On dresp.data_ok=1 in BUSY: next state IDLE, busy=0.
  - Data and data_ok reach the owner in that same cycle.
  - A master still holding valid afterwards is re-arbitrated normally in IDLE; no back-to-back grant without passing IDLE.
- Owner drops valid before data_ok:
  - The request is still forwarded (dreq.valid=0).
  - The arbiter stays BUSY until data_ok; the bus slave defines that case as illegal.
- Non-owner requests during BUSY:
  - Ignored and stalled (resp zero); no queueing inside the arbiter.
  - The master must hold valid until granted.
- Simultaneous data_ok and a new request in the same cycle: the new request is arbitrated in the IDLE cycle that follows.
- dresp outside BUSY is ignored.
- owner holds its value in IDLE; it changes only on a grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog (width = $clog2(TIMEOUT_CYCLES+1)) clears on entry to BUSY and increments each BUSY cycle without data_ok.
  - When it reaches TIMEOUT_CYCLES: force IDLE, pulse timeout_err for one cycle, and drive the owner's resp with data_ok=1, data=0 in that cycle so the master unblocks.
  - data_ok in the same cycle as the limit takes precedence; no error.
- Not defined:
  - No counter logic; timeout_err tied 0.
  - BUSY waits indefinitely for data_ok.

Test Plan:
- m1 read addr=0x8000_0010, slave data_ok after 3 cycles with data=0xDEAD_BEEF_0123_4567 -> dreq.valid rises 1 cycle after m1 valid; m1_resp.data_ok=1 with that data; m0_resp stays 0; busy drops next cycle.
- RR_EN=0, m0 and m1 valid in same cycle -> owner=1; m0 gets grant only after m1's data_ok plus one IDLE cycle.
- RR_EN=1, both masters continuously valid for 4 transactions -> grant order 1,0,1,0.
- m0 request during m1's BUSY with m0 addr=0x8000_0000 -> dreq.addr never shows 0x8000_0000 until m1 completes.
- rst asserted in the 2nd BUSY cycle -> next cycle: dreq.valid=0, busy=0, owner=0; late dresp.data_ok is ignored.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds -> timeout_err pulses in the 8th BUSY cycle; owner resp data_ok=1, data=0; state returns to IDLE.
